spi_ram_slave: RTL and testbench
================================

Name: spi_ram_slave

Overview:
- SPI-side responder to the write/read command path: a mode-0 SPI slave fronting a small register-file RAM.
- Decodes frames from the SPI master: command bit, address, data.
  - Write frames commit the data word to the RAM.
  - Read frames shift the addressed word back on MISO.
- Sits at the far end of the SPI link, in the CLK domain; SCLK/CSN/MOSI are oversampled.

Parameters:
- DATA_BIT, 4, data word width; RAM word width.
- ADDR_BIT, 3, address width; RAM depth = 2**ADDR_BIT.
- FRAME_BIT, 1+ADDR_BIT+DATA_BIT (derived, not overridable), SCLK bits per frame.

Ports:
- CLK  in  1  system clock; SCLK period must be >= 8 CLK cycles.
- RSTN  in  1  reset, asynchronous, active-low.
- SCLK  in  1  SPI clock from master, asynchronous to CLK, idle low.
- CSN  in  1  chip select, active-low, asynchronous.
- MOSI  in  1  serial in, MSB first.
- MISO  out  1  serial out, MSB first.
- MISO_OE  out  1  high while a read data phase is active; pad tristate enable.
- WR_DONE  out  1  one-CLK pulse when a write commits.
- RD_DONE  out  1  one-CLK pulse when the last read bit has been sampled by the master.
- FRAME_ERR  out  1  one-CLK pulse when CSN rises on an incomplete frame.
- LAST_ADDR  out  ADDR_BIT  address of the most recent completed frame.

Behaviour:
- Reset (RSTN low, async):
  - FSM to IDLE; all outputs 0; LAST_ADDR=0.
  - Shift/bit counters cleared; all RAM words cleared to 0.
- Input synchronisation:
  - SCLK, CSN, MOSI each pass a 2-FF synchroniser.
  - SCLK rise/fall and CSN fall/rise are detected from the synchronised values (1-CLK pulses).
  - MOSI is sampled from its synchronised copy on the SCLK-rise pulse.
- Frame format:
  - Bit 0 is CMD: 1 = write, 0 = read.
  - Next ADDR_BIT bits are the address, MSB first.
  - Next DATA_BIT bits are the data, MSB first.
- FSM states: IDLE, CMD, ADDR, DATA, HOLD.
  - IDLE -> CMD on CSN fall.
  - CMD -> ADDR on first SCLK rise; latch CMD.
  - ADDR -> DATA after ADDR_BIT rises; address register complete.
  - DATA -> HOLD after DATA_BIT rises.
  - Any state except IDLE -> IDLE on CSN rise.
  - SCLK edges while CSN is high are ignored.
- Write path:
  - On the SCLK rise carrying the last data bit: RAM[addr] <= shifted data in the same CLK.
  - WR_DONE pulses 1 CLK later; LAST_ADDR updates.
- Read path:
  - On the SCLK rise carrying the last address bit, RAM[addr] loads the TX shift register (registered read, 1 CLK).
  - MISO presents the data MSB at the following SCLK fall; the register shifts on each later fall.
  - MISO_OE=1 from that fall until CSN rises.
  - MOSI data bits during a read are don't-care and ignored.
  - RD_DONE pulses on the SCLK rise of the last data bit; LAST_ADDR updates.
- Outside the read data phase, MISO=0 and MISO_OE=0.
- HOLD:
  - Extra SCLK edges beyond FRAME_BIT are ignored: no shift, no second commit.
  - MISO held 0 after the last read bit.
- Abort: CSN rise before FRAME_BIT rises completes the frame:
  - no RAM write, no WR_DONE/RD_DONE;
  - FRAME_ERR pulses 1 CLK;
  - return to IDLE.
  - A CSN rise in HOLD is a normal end, with no FRAME_ERR.
- CSN fall while not IDLE (glitch-free re-select after a rise) always restarts in CMD with counters cleared.
- Address width: no wrap arithmetic inside a frame. The address is used as-is; all 2**ADDR_BIT locations are valid.
- Async reset mid-frame: immediate return to reset state; the partial frame is discarded.

Decomposition:
- Package spi_ram_pkg:
  - state enum (IDLE, CMD, ADDR, DATA, HOLD);
  - CMD_WR=1'b1 and CMD_RD=1'b0 constants;
  - FRAME_BIT derivation helper.
- Sub-module spi_sync_edge:
  - 2-FF synchroniser plus rise/fall pulse generator;
  - instanced for SCLK and CSN;
  - MOSI uses its sync output only.

Test Plan:
- Write frame, CMD=1, ADDR=3'b101, DATA=4'b1010 -> WR_DONE pulse once, RAM[5]=4'hA, LAST_ADDR=5, MISO_OE=0 throughout.
- Read frame, CMD=0, ADDR=5, after the test above -> MISO bits 1,0,1,0 on the 4 data rises; RD_DONE pulse once; RAM unchanged.
- Abort: CSN rises after 5 SCLK rises of a write to addr 2 with data 4'hF -> FRAME_ERR pulse, no WR_DONE, RAM[2] still 0.
- Over-clock: write frame to addr 7, data 4'h3, followed by 3 extra SCLK pulses before CSN rise -> single WR_DONE, RAM[7]=4'h3, no FRAME_ERR.
- Sweep: write data=addr^4'h9 to all 8 addresses, then read all back -> each read returns the written word; 8 WR_DONE and 8 RD_DONE pulses.
- Reset mid-frame: RSTN low after 6 SCLK rises of a write to addr 1 -> all outputs 0 immediately, RAM all 0; next complete read of addr 1 returns 0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-fronted register-file RAM.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_e;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  function automatic int frame_bits(input int addr_bit, input int data_bit);
    return 1 + addr_bit + data_bit;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser for an asynchronous SPI pin with 1-CLK rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_o,
  output logic fall_o
);

  // [1:0] is the synchroniser, [2] the previous synchronised value
  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_ram_slave.sv
// Mode-0 SPI slave: decodes {cmd, addr, data} frames into writes/reads of a small RAM.
module spi_ram_slave
  import spi_ram_pkg::*;
#(
  parameter int DATA_BIT = 4,
  parameter int ADDR_BIT = 3
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                SCLK,
  input  logic                CSN,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_OE,
  output logic                WR_DONE,
  output logic                RD_DONE,
  output logic                FRAME_ERR,
  output logic [ADDR_BIT-1:0] LAST_ADDR
);

  localparam int FRAME_BIT = frame_bits(ADDR_BIT, DATA_BIT);
  localparam int CNT_W     = $clog2(FRAME_BIT + 1);
  localparam int DEPTH     = 1 << ADDR_BIT;

  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic mosi_meta_q, mosi_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(CLK), .rst_n(RSTN), .din(SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // CSN idles high, so its synchroniser resets high to avoid a false rise
  spi_sync_edge #(.RST_VAL(1'b1)) u_csn (
    .clk(CLK), .rst_n(RSTN), .din(CSN), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cmd_q, cmd_d;
  logic [ADDR_BIT-1:0]  addr_q, addr_d, addr_nxt;
  logic [DATA_BIT-1:0]  rx_q, rx_d, rx_nxt;
  logic [DATA_BIT-1:0]  tx_q, tx_d;
  logic                 miso_q, miso_d, oe_q, oe_d;
  logic                 wr_done_q, wr_done_d, rd_done_q, rd_done_d, ferr_q, ferr_d;
  logic [ADDR_BIT-1:0]  last_q, last_d;
  logic [DATA_BIT-1:0]  mem_q [DEPTH];
  logic [DATA_BIT-1:0]  mem_d [DEPTH];

  assign addr_nxt = ADDR_BIT'({addr_q, mosi_q});
  assign rx_nxt   = DATA_BIT'({rx_q, mosi_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    ferr_d    = 1'b0;
    last_d    = last_q;
    mem_d     = mem_q;
    if (csn_rise && state_q != S_IDLE) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
      ferr_d  = (state_q != S_HOLD);
    end else if (csn_fall) begin
      state_d = S_CMD;
      cnt_d   = '0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (sclk_rise) begin
      case (state_q)
        S_CMD: begin
          cmd_d   = mosi_q;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d = addr_nxt;
          if (cnt_q == CNT_W'(ADDR_BIT - 1)) begin
            cnt_d   = '0;
            state_d = S_DATA;
            if (cmd_q == CMD_RD) tx_d = mem_q[addr_nxt];
          end else cnt_d = cnt_q + 1'b1;
        end
        S_DATA: begin
          rx_d = rx_nxt;
          if (cnt_q == CNT_W'(DATA_BIT - 1)) begin
            state_d = S_HOLD;
            last_d  = addr_q;
            if (cmd_q == CMD_WR) begin
              mem_d[addr_q] = rx_nxt;
              wr_done_d     = 1'b1;
            end else rd_done_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end else if (sclk_fall) begin
      // the first fall after the last address bit presents the MSB
      if (state_q == S_DATA && cmd_q == CMD_RD) begin
        miso_d = tx_q[DATA_BIT-1];
        tx_d   = tx_q << 1;
        oe_d   = 1'b1;
      end else if (state_q == S_HOLD) miso_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      ferr_q      <= 1'b0;
      last_q      <= '0;
      mem_q       <= '{default: '0};
    end else begin
      mosi_meta_q <= MOSI;
      mosi_q      <= mosi_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      ferr_q      <= ferr_d;
      last_q      <= last_d;
      mem_q       <= mem_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_OE   = oe_q;
  assign WR_DONE   = wr_done_q;
  assign RD_DONE   = rd_done_q;
  assign FRAME_ERR = ferr_q;
  assign LAST_ADDR = last_q;

endmodule

// File: tb/tb_spi_ram_slave.sv
// Randomised frame bench for spi_ram_slave against an array-based RAM model.
module tb_spi_ram_slave;

  logic       CLK = 1'b0;
  logic       RSTN, SCLK, CSN, MOSI;
  logic       MISO, MISO_OE, WR_DONE, RD_DONE, FRAME_ERR;
  logic [2:0] LAST_ADDR;

  spi_ram_slave #(.DATA_BIT(4), .ADDR_BIT(3)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCLK(SCLK), .CSN(CSN), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .WR_DONE(WR_DONE), .RD_DONE(RD_DONE),
    .FRAME_ERR(FRAME_ERR), .LAST_ADDR(LAST_ADDR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, oe_cnt = 0;
  logic [3:0] ram_m [8];
  logic [2:0] last_m;

  always @(negedge CLK) begin
    wr_cnt   += int'(WR_DONE);
    rd_cnt   += int'(RD_DONE);
    ferr_cnt += int'(FRAME_ERR);
    oe_cnt   += int'(MISO_OE);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // nr rises of the frame proper (8 = complete), then extra rises in HOLD
  task automatic run_frame(input string tag, input logic cmd, input logic [2:0] a,
                           input logic [3:0] d, input int nr, input int extra);
    logic [7:0] vec;
    logic [3:0] got;
    int w0, r0, f0, o0;
    vec = {cmd, a, d};
    got = '0;
    w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt; o0 = oe_cnt;
    CSN = 1'b0;
    clks(6);
    for (int i = 0; i < nr + extra; i++) begin
      if (i < 8 && !(cmd == 1'b0 && i >= 4)) MOSI = vec[7-i];
      else                                   MOSI = 1'($urandom);
      clks(6);
      SCLK = 1'b1;
      if (i >= 4 && i < 8) got[7-i] = MISO;
      clks(6);
      SCLK = 1'b0;
    end
    clks(6);
    CSN = 1'b1;
    clks(8);
    if (nr < 8) begin
      chk({tag, ".ferr"}, ferr_cnt - f0, 1);
      chk({tag, ".wr"},   wr_cnt - w0,   0);
      chk({tag, ".rd"},   rd_cnt - r0,   0);
    end else begin
      chk({tag, ".ferr"}, ferr_cnt - f0, 0);
      if (cmd) begin
        ram_m[a] = d;
        chk({tag, ".wr"}, wr_cnt - w0, 1);
        chk({tag, ".rd"}, rd_cnt - r0, 0);
        chk({tag, ".oe"}, oe_cnt - o0, 0);
      end else begin
        chk({tag, ".wr"},   wr_cnt - w0, 0);
        chk({tag, ".rd"},   rd_cnt - r0, 1);
        chk({tag, ".data"}, got, ram_m[a]);
      end
      last_m = a;
    end
    chk({tag, ".last"}, LAST_ADDR, last_m);
    chk({tag, ".idle"}, {MISO_OE, MISO}, 2'b00);
  endtask

  initial begin
    logic [2:0] ra;
    logic [7:0] vec;
    int w0, r0, f0, nr;
    RSTN = 1'b0; CSN = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    for (int i = 0; i < 8; i++) ram_m[i] = '0;
    last_m = '0;
    clks(4);
    chk("reset.outs", {MISO, MISO_OE, WR_DONE, RD_DONE, FRAME_ERR, LAST_ADDR}, '0);
    RSTN = 1'b1;
    clks(6);

    run_frame("wr5",   1'b1, 3'd5, 4'hA, 8, 0);
    run_frame("rd5",   1'b0, 3'd5, 4'h0, 8, 0);
    run_frame("abort", 1'b1, 3'd2, 4'hF, 5, 0);
    run_frame("rd2",   1'b0, 3'd2, 4'h0, 8, 0);
    run_frame("over7", 1'b1, 3'd7, 4'h3, 8, 3);
    run_frame("rd7",   1'b0, 3'd7, 4'h0, 8, 0);

    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 8; i++) run_frame("sweep_wr", 1'b1, 3'(i), 4'(i) ^ 4'h9, 8, 0);
    for (int i = 0; i < 8; i++) run_frame("sweep_rd", 1'b0, 3'(i), 4'h0, 8, 0);
    chk("sweep.wr_total", wr_cnt - w0, 8);
    chk("sweep.rd_total", rd_cnt - r0, 8);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(3, 0))
        0:       nr = $urandom_range(7, 1);
        default: nr = 8;
      endcase
      run_frame("rand", 1'($urandom), 3'($urandom), 4'($urandom), nr,
                (nr == 8) ? $urandom_range(3, 0) : 0);
    end

    // asynchronous reset after 6 rises of a write to address 1
    f0 = ferr_cnt; w0 = wr_cnt;
    vec = {1'b1, 3'd1, 4'hC};
    CSN = 1'b0;
    clks(6);
    for (int i = 0; i < 6; i++) begin
      MOSI = vec[7-i];
      clks(6);
      SCLK = 1'b1;
      clks(i == 5 ? 3 : 6);
      if (i != 5) SCLK = 1'b0;
    end
    RSTN = 1'b0;
    #1;
    chk("rst_mid.outs", {MISO, MISO_OE, WR_DONE, RD_DONE, FRAME_ERR, LAST_ADDR}, '0);
    SCLK = 1'b0; CSN = 1'b1;
    clks(4);
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) ram_m[i] = '0;
    last_m = '0;
    clks(6);
    chk("rst_mid.ferr", ferr_cnt - f0, 0);
    chk("rst_mid.wr",   wr_cnt - w0,   0);
    run_frame("rd1_after_rst", 1'b0, 3'd1, 4'h0, 8, 0);
    for (int i = 0; i < 3; i++) begin
      ra = 3'($urandom);
      run_frame("rd_after_rst", 1'b0, ra, 4'h0, 8, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
